// File: rtl/mul_add2_result_reader.sv
// Snapshots the mul_add2 result vector on start and streams it out one element per transfer.
// Latency: first element valid the cycle after start is sampled; done pulses the cycle after the last transfer.
// Backpressure: out_valid/out_data/out_index/out_last hold unchanged while out_ready is low.
module mul_add2_result_reader #(
    parameter int number_of_equations_per_cluster = 9,
    parameter int element_width                   = 32,
    parameter int index_width                     = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic [element_width*number_of_equations_per_cluster-1:0] memory_input,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [element_width-1:0]                             out_data,
    output logic [index_width-1:0]                               out_index,
    output logic                                                 out_last,
    output logic                                                 busy,
    output logic                                                 done
);

    localparam int VEC_W = element_width * number_of_equations_per_cluster;
    localparam logic [index_width-1:0] LAST_IDX = index_width'(number_of_equations_per_cluster - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]             state;
    logic [VEC_W-1:0]       shadow;
    logic [index_width-1:0] index;
    logic                   xfer;

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= '0;
            index  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow <= memory_input;
                        index  <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    // The transfer of the last element leaves STREAM, so index never wraps.
                    if (xfer) begin
                        if (index == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            index <= index + index_width'(1);
                        end
                    end
                end
                DONE: begin
                    index <= '0;
                    state <= IDLE;
                end
                default: begin
                    index <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so they are stable under backpressure.
    always_comb begin
        out_valid = (state == STREAM);
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_data  = shadow[int'(index)*element_width +: element_width];
            out_index = index;
            out_last  = (index == LAST_IDX);
        end
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_mul_add2_result_reader.sv
// Directed bench for mul_add2_result_reader: N=9 instance for streaming/backpressure/reset cases, N=1 instance for the single-element case.
module tb_mul_add2_result_reader;

    localparam int N  = 9;
    localparam int EW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [EW*N-1:0] memory_input;
    logic            out_valid;
    logic            out_ready;
    logic [EW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic            busy;
    logic            done;

    logic            start1;
    logic [EW-1:0]   memory_input1;
    logic            out_valid1;
    logic            out_ready1;
    logic [EW-1:0]   out_data1;
    logic [IW-1:0]   out_index1;
    logic            out_last1;
    logic            busy1;
    logic            done1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_add2_result_reader #(
        .number_of_equations_per_cluster(N),
        .element_width(EW),
        .index_width(IW)
    ) u_dut9 (
        .clk(clk), .rst(rst), .start(start), .memory_input(memory_input),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    mul_add2_result_reader #(
        .number_of_equations_per_cluster(1),
        .element_width(EW),
        .index_width(IW)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .memory_input(memory_input1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < N; k++) memory_input[k*EW +: EW] = EW'(k + 1);
    endtask

    task automatic chk_elem(input string tag, input int k);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"},  64'(out_data),  64'(k + 1));
        chk({tag, "_index"}, 64'(out_index), 64'(k));
        chk({tag, "_last"},  64'(out_last),  64'(k == N - 1));
        chk({tag, "_busy"},  64'(busy),      64'd1);
        chk({tag, "_done"},  64'(done),      64'd0);
    endtask

    initial begin
        int  nxt;
        bit  expect_done;
        bit  finished;

        rst = 1'b1; start = 1'b0; memory_input = '0; out_ready = 1'b0;
        start1 = 1'b0; memory_input1 = '0; out_ready1 = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        rst = 1'b0;
        step();

        // 1: no backpressure, elements 1..9 on cycles 1..9, done on cycle 10
        load_ramp();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk_elem("t1", k);
            step();
        end
        chk("t1_done",       64'(done),      64'd1);
        chk("t1_done_busy",  64'(busy),      64'd1);
        chk("t1_done_valid", 64'(out_valid), 64'd0);
        chk("t1_done_last",  64'(out_last),  64'd0);
        chk("t1_done_data",  64'(out_data),  64'd0);
        step();
        chk("t1_idle_busy",  64'(busy),      64'd0);
        chk("t1_idle_done",  64'(done),      64'd0);

        // 2: backpressure, held for cycles 1-3 then alternate ready
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("t2_hold_data",  64'(out_data),  64'd1);
            chk("t2_hold_index", 64'(out_index), 64'd0);
            chk("t2_hold_valid", 64'(out_valid), 64'd1);
            step();
        end
        nxt = 0; expect_done = 1'b0; finished = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            out_ready = (c % 2 == 0);
            if (expect_done) begin
                chk("t2_done", 64'(done), 64'd1);
                finished = 1'b1;
            end else begin
                chk("t2_no_early_done", 64'(done), 64'd0);
                if (out_valid) begin
                    chk("t2_data",  64'(out_data),  64'(nxt + 1));
                    chk("t2_index", 64'(out_index), 64'(nxt));
                    if (out_ready) begin
                        nxt++;
                        if (nxt == N) expect_done = 1'b1;
                    end
                end
            end
            step();
        end
        chk("t2_complete", 64'(finished), 64'd1);
        chk("t2_count",    64'(nxt),      64'(N));
        chk("t2_idle",     64'(busy),     64'd0);

        // 3: snapshot isolation
        for (int k = 0; k < N; k++) memory_input[k*EW +: EW] = 32'hA5A5A5A5;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        memory_input = '1;
        for (int k = 0; k < N; k++) begin
            chk("t3_data", 64'(out_data), 64'hA5A5A5A5);
            step();
        end
        chk("t3_done", 64'(done), 64'd1);
        step();

        // 4: start held continuously; second vector starts at cycle 12
        load_ramp();
        start = 1'b1;
        step();
        for (int k = 0; k < N; k++) begin
            chk_elem("t4a", k);
            step();
        end
        chk("t4_done", 64'(done), 64'd1);
        step();
        chk("t4_idle_busy",  64'(busy),      64'd0);
        chk("t4_idle_valid", 64'(out_valid), 64'd0);
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk_elem("t4b", k);
            step();
        end
        chk("t4b_done", 64'(done), 64'd1);
        step();

        // 5: reset at cycle 4 of a stream
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("t5_pre_index", 64'(out_index), 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_busy",  64'(busy),      64'd0);
        chk("t5_done",  64'(done),      64'd0);
        chk("t5_data",  64'(out_data),  64'd0);
        step();
        chk("t5_no_done", 64'(done), 64'd0);
        chk("t5_no_busy", 64'(busy), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk_elem("t5r", k);
            step();
        end
        chk("t5r_done", 64'(done), 64'd1);
        step();

        // 6: N=1 instance
        memory_input1 = 32'h12345678;
        out_ready1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("t6_valid", 64'(out_valid1), 64'd1);
        chk("t6_last",  64'(out_last1),  64'd1);
        chk("t6_data",  64'(out_data1),  64'h12345678);
        chk("t6_index", 64'(out_index1), 64'd0);
        chk("t6_busy",  64'(busy1),      64'd1);
        step();
        chk("t6_done",  64'(done1),      64'd1);
        chk("t6_dvalid", 64'(out_valid1), 64'd0);
        step();
        chk("t6_idle",  64'(busy1),      64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_add2_result_reader.md
Name: mul_add2_result_reader

Overview:
Read-side companion to the single-entry mul_add2 result store. It takes the store's wide parallel output (number_of_equations_per_cluster packed elements) as a snapshot on a start command. It then streams the elements one per transfer over a valid/ready interface to the downstream consumer (serial adder / writeback path). It flags the last element and pulses done when the vector has been fully drained.

Parameters:
number_of_equations_per_cluster, 9, elements per packed vector (N, >=1)
element_width, 32, bits per element
index_width, 4, width of element index; 2^index_width >= N required

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  request to snapshot memory_input and begin streaming; honoured only in IDLE
memory_input  input  element_width*N  packed vector from the result store; element k = bits [k*element_width +: element_width]
out_valid  output  1  out_data/out_index/out_last hold a valid element
out_ready  input  1  consumer accepts element when out_valid && out_ready
out_data  output  element_width  current element
out_index  output  index_width  index k of current element
out_last  output  1  current element is k = N-1 (qualified by out_valid)
busy  output  1  high in STREAM and DONE
done  output  1  one-cycle pulse after last transfer

Behaviour:
- One clock domain, one clock (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0. Shadow register cleared to 0.
- rst has priority over all other inputs. Asserted mid-stream, it aborts the vector with no done pulse. All outputs take their reset values at that edge.
- States: IDLE, STREAM, DONE.
- IDLE:
  - If start=1: capture memory_input into the shadow register, set index=0, go to STREAM.
  - Otherwise remain in IDLE.
- STREAM:
  - out_valid=1, out_data=shadow element[index], out_index=index, out_last=(index==N-1), busy=1.
  - Latency: first valid element is presented the cycle after start is sampled.
  - Transfer occurs on an edge where out_valid && out_ready.
  - Transfer with index<N-1: index increments, stay in STREAM.
  - Transfer with index==N-1: go to DONE.
  - No transfer: all outputs hold exactly (stable under backpressure).
  - Maximum throughput is one element per cycle with out_ready held high.
- DONE (one cycle):
  - out_valid=0, out_last=0, done=1, busy=1.
  - Next state is IDLE unconditionally.
- start is ignored in STREAM and DONE; it is not queued. A new vector requires start in IDLE.
- Snapshot isolation: memory_input changes after the capture edge do not affect the stream in progress.
- N=1: single element with out_last=1 on the first presentation. DONE follows its transfer.
- out_data, out_index and out_last are don't-care-free: they are driven to 0 when out_valid=0.
- No arithmetic beyond the index increment. The index never wraps because the transfer at N-1 exits STREAM.

Test Plan:
1. Streaming with no backpressure:
   - Stimulus: reset; memory_input with element k = k+1 (N=9); start pulse at cycle 0; out_ready held 1.
   - Response: out_valid cycles 1-9 with out_data 1..9 and out_index 0..8; out_last only at cycle 9; done=1 only at cycle 10; busy cycles 1-10; IDLE at cycle 11.
2. Backpressure:
   - Stimulus: same vector; out_ready=0 for cycles 1-3, 1 on alternate cycles thereafter.
   - Response: out_data=1/out_index=0 held through cycle 3; each element transferred exactly once, in order; done exactly one cycle after the transfer of 9.
3. Snapshot isolation:
   - Stimulus: start with all elements 0xA5A5A5A5; change memory_input to 0xFFFFFFFF the cycle after start.
   - Response: all 9 transferred elements equal 0xA5A5A5A5.
4. Start while busy:
   - Stimulus: start asserted continuously from cycle 0.
   - Response: the stream completes normally; a second stream starts only from IDLE (first valid of vector 2 at cycle 12). No element is skipped or repeated.
5. Reset mid-operation:
   - Stimulus: assert rst at cycle 4 of a stream.
   - Response: next edge has out_valid=0, busy=0, done=0, out_data=0; done never pulses; a new start streams from index 0.
6. Single-element configuration:
   - Stimulus: N=1 build, element 0x12345678, start.
   - Response: cycle 1 out_valid=1, out_last=1, out_data=0x12345678; done at cycle 2.
